// File: rtl/accel_pkg.sv
// accel_pkg: shared constants and helpers for accelerator stream buffers
package accel_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 16;
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_regfile.sv
// fifo_regfile: DEPTH x WIDTH array, one synchronous write port, one asynchronous read port
module fifo_regfile #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/stream_drain_fifo.sv
// stream_drain_fifo: first-word-fall-through valid/ready FIFO with occupancy, almost-full, last and overflow tracking
module stream_drain_fifo
  import accel_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int AFULL_THRESH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     overflow
);
  localparam int PW = ptr_w(DEPTH);
  localparam int IW = PW - 1;
  localparam logic [PW-1:0] AF_T = PW'(AFULL_THRESH);
  logic [PW-1:0] wr_ptr, rd_ptr, count_next;
  logic [WIDTH:0] rd_word;
  logic empty, full, push, pop;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) && (wr_ptr[IW] != rd_ptr[IW]);
  assign in_ready = !rst && !full;
  assign out_valid = !empty;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign count = wr_ptr - rd_ptr;
  assign count_next = count + PW'(push) - PW'(pop);
  assign out_data = empty ? '0 : rd_word[WIDTH-1:0];
  assign out_last = empty ? 1'b0 : rd_word[WIDTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr + PW'(push);
      rd_ptr      <= rd_ptr + PW'(pop);
      almost_full <= count_next >= AF_T;
      overflow    <= overflow || (in_valid && full);
    end
  end
  fifo_regfile #(.WIDTH(WIDTH + 1), .DEPTH(DEPTH)) u_regfile (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr[IW-1:0]),
    .wdata({in_last, in_data}),
    .raddr(rd_ptr[IW-1:0]),
    .rdata(rd_word)
  );
endmodule

// File: tb/tb_stream_drain_fifo.sv
// tb_stream_drain_fifo: directed and random stimulus checked by a queue scoreboard in a separate monitor
module tb_stream_drain_fifo;
  localparam int W = 32, D = 16, AF = 12;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_last = 0, in_ready, out_valid, out_last, out_ready = 0;
  logic [W-1:0] in_data = '0, out_data;
  logic [$clog2(D):0] count;
  logic almost_full, overflow;
  logic [W:0] q [$];
  int cmp = 0, bad = 0, pops = 0, lasts = 0;
  bit ovf_m = 0, prev_hold = 0;
  logic [W-1:0] prev_d;

  stream_drain_fifo #(.WIDTH(W), .DEPTH(D), .AFULL_THRESH(AF)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .count(count), .almost_full(almost_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    cmp++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // Monitor: compares DUT outputs against the queue model once per cycle, away from the rising edge
  always @(negedge clk) begin
    int sz;
    logic [W:0] e;
    if (rst) begin
      chk("in_ready_rst", in_ready, 0);
      q.delete();
      ovf_m = 0;
      prev_hold = 0;
    end else begin
      sz = q.size();
      chk("count", count, sz);
      chk("out_valid", out_valid, sz != 0);
      chk("in_ready", in_ready, sz < D);
      chk("almost_full", almost_full, sz >= AF);
      chk("overflow", overflow, ovf_m);
      if (prev_hold) chk("stall_stable", out_data, prev_d);
      if (out_valid && out_ready) begin
        pops++;
        if (sz == 0) chk("pop_when_empty", 1, 0);
        else begin
          e = q.pop_front();
          chk("out_data", out_data, e[W-1:0]);
          chk("out_last", out_last, e[W]);
          if (e[W]) lasts++;
        end
      end
      if (in_valid && sz < D) q.push_back({in_last, in_data});
      else if (in_valid) ovf_m = 1;
      prev_hold = out_valid && !out_ready;
      prev_d = out_data;
    end
  end

  task automatic cyc(input logic v, input logic [W-1:0] d, input logic l, input logic r);
    in_valid = v; in_data = d; in_last = l; out_ready = r;
    @(posedge clk); #1;
  endtask

  initial begin
    int p0, l0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_overflow", overflow, 0);
    rst = 0;
    for (int i = 1; i <= D; i++) begin
      cyc(1, W'(i), 0, 0);
      if (i == 11) chk("afull_at_11", almost_full, 0);
      if (i == 12) chk("afull_at_12", almost_full, 1);
    end
    chk("fill_count", count, 16);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_head", out_data, 32'h1);
    cyc(1, 32'h99, 0, 1);
    chk("fullpop_count", count, 15);
    chk("fullpop_in_ready", in_ready, 1);
    chk("fullpop_overflow", overflow, 1);
    chk("fullpop_head", out_data, 32'h2);
    repeat (16) cyc(0, '0, 0, 1);
    chk("drain_count", count, 0);
    chk("drain_out_valid", out_valid, 0);
    p0 = pops;
    for (int i = 0; i < 100; i++) cyc(1, 32'h1000 + W'(i), 0, 1);
    chk("stream_count", count, 1);
    cyc(0, '0, 0, 1);
    chk("stream_pops", pops - p0, 100);
    l0 = lasts;
    for (int i = 1; i <= 40; i++) cyc(1, 32'h2000 + W'(i), i == 7 || i == 33, 1);
    cyc(0, '0, 0, 1);
    chk("last_seen", lasts - l0, 2);
    chk("wrap_empty", out_valid, 0);
    for (int i = 0; i < 10000; i++)
      cyc(i < 5000 ? $urandom_range(0, 3) != 0 : $urandom_range(0, 3) == 0, $urandom,
          $urandom_range(0, 7) == 0, i < 5000 ? $urandom_range(0, 1) == 1 : $urandom_range(0, 3) != 0);
    repeat (20) cyc(0, '0, 0, 1);
    chk("rand_drained", count, 0);
    for (int i = 1; i <= 9; i++) cyc(1, 32'h3000 + W'(i), 0, 0);
    chk("pre_rst_count", count, 9);
    rst = 1;
    cyc(0, '0, 0, 0);
    rst = 0;
    chk("midrst_count", count, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_overflow", overflow, 0);
    chk("midrst_afull", almost_full, 0);
    cyc(1, 32'hAA, 1, 0);
    chk("post_rst_head", out_data, 32'hAA);
    chk("post_rst_last", out_last, 1);
    repeat (3) cyc(0, '0, 0, 1);
    chk("final_empty", out_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
